// File: rtl/sram_dma_master.sv
// -----------------------------------------------------------------------------
// sram_dma_master
//   Block-transfer DMA engine for a zero-wait-state 16-bit SRAM-style memory
//   port. A command moves cmd_len words starting at cmd_addr, either from the
//   write-data stream into memory or from memory into the read-data stream.
//   Reads are pipelined. Returns land in a small FIFO, and new reads are only
//   issued while in-flight reads plus buffered words leave room in it.
//
// Ports
//   clk, reset                  single rising-edge clock, async active-low reset
//   cmd_valid/ready/write/addr/len   command handshake (len = 0 -> immediate done)
//   wr_data/wr_valid/wr_ready   write-data stream (passed straight to memory)
//   rd_data/rd_valid/rd_ready   read-data stream (FIFO head)
//   address/byteenable/read/write/writedata/readdata/readdatavalid
//                               memory side, every access accepted immediately
//   busy, done                  status; done is a one-cycle pulse
// -----------------------------------------------------------------------------
module sram_dma_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [19:0] cmd_addr,
  input  logic [19:0] cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [19:0] address,
  output logic [1:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        readdatavalid,
  output logic        busy,
  output logic        done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;  // counters must reach FIFO_DEPTH itself
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic [19:0]     r_addr;
  logic [19:0]     r_len;
  logic            r_started;      // holds cmd_ready low until the first edge after reset
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [15:0]     r_mem [FIFO_DEPTH];

  logic [CW:0]     w_inflight;
  logic            w_issue_rd;
  logic            w_issue_wr;
  logic            w_push;
  logic            w_pop;

  // Every word already requested or already buffered will occupy a FIFO slot.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_issue_rd = (r_state == S_READ) && (w_inflight < DEPTH_C);
  assign w_issue_wr = (r_state == S_WRITE) && wr_valid;
  // Stray returns (nothing outstanding, e.g. after a reset abort) are dropped.
  assign w_push     = readdatavalid && (r_outstanding != '0);
  assign w_pop      = rd_valid && rd_ready;

  assign cmd_ready  = r_started && (r_state == S_IDLE);
  assign wr_ready   = (r_state == S_WRITE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign read       = w_issue_rd;
  assign write      = w_issue_wr;
  assign byteenable = (w_issue_rd || w_issue_wr) ? 2'b11 : 2'b00;
  assign address    = r_addr;
  assign writedata  = w_issue_wr ? wr_data : 16'h0000;
  assign rd_valid   = (r_count != '0);
  assign rd_data    = r_mem[r_rd_ptr];

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_addr <= cmd_addr;
            r_len  <= cmd_len;
            if (cmd_len == '0)  r_state <= S_DONE;
            else if (cmd_write) r_state <= S_WRITE;
            else                r_state <= S_READ;
          end
        end
        S_WRITE: begin
          if (w_issue_wr) begin
            r_addr <= r_addr + 20'd1;  // wraps modulo 2^20
            r_len  <= r_len - 20'd1;
            if (r_len == 20'd1) r_state <= S_DONE;
          end
        end
        S_READ: begin
          if (w_issue_rd) begin
            r_addr <= r_addr + 20'd1;
            r_len  <= r_len - 20'd1;
            if (r_len == 20'd1) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_outstanding == '0 && r_count == '0) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // In-flight read tracking and FIFO occupancy/pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      if (w_issue_rd && !w_push)      r_outstanding <= r_outstanding + ONE_C;
      else if (!w_issue_rd && w_push) r_outstanding <= r_outstanding - ONE_C;

      if (w_push && !w_pop)      r_count <= r_count + ONE_C;
      else if (!w_push && w_pop) r_count <= r_count - ONE_C;

      // FIFO_DEPTH is a power of two, so pointers wrap naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; r_count gates every read of
  // it, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= readdata;
  end

endmodule

// File: tb/tb_sram_dma_master.sv
// -----------------------------------------------------------------------------
// tb_sram_dma_master
//   Randomized self-checking bench for sram_dma_master. A behavioural memory
//   with configurable read latency feeds the DUT; a negedge monitor logs every
//   memory access, pop and done pulse. Each test task compares these logs
//   against expectations derived from the command (addresses addr+i mod 2^20,
//   data from the memory function or the words that were offered).
// -----------------------------------------------------------------------------
module tb_sram_dma_master;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [19:0] cmd_addr = '0, cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, rd_ready = 1'b0;
  logic [19:0] address;
  logic [1:0]  byteenable;
  logic        read, write;
  logic [15:0] writedata, readdata;
  logic        readdatavalid;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_dma_master #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .busy(busy), .done(done)
  );

  // ---------------- memory model ----------------
  int          cyc = 0;
  int          mem_lat = 2;        // 1..4 cycles, changed only while idle
  logic        spur = 1'b0;        // injects a stray readdatavalid
  logic [15:0] mem_seed = '0;
  logic [3:0]  pipe_v = '0;
  logic [19:0] pipe_a [4];

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    return (a[15:0] * 16'h9E37) ^ {a[19:16], a[19:8]} ^ mem_seed;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    pipe_v <= {pipe_v[2:0], read};
    pipe_a[0] <= address;
    for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
  end

  always_comb begin
    readdatavalid = pipe_v[mem_lat-1] | spur;
    readdata      = mem_word(pipe_a[mem_lat-1]);
  end

  // ---------------- monitor + reference occupancy model ----------------
  logic [19:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  logic [19:0] ra_q[$];
  logic [15:0] pop_q[$];
  int          popc_q[$];
  int          done_q[$];
  logic [15:0] fifo_m[$];
  logic [15:0] exp_wd[$];
  int          out_m = 0;
  int          viol = 0;
  int          acc_cyc = 0;
  int          hold_reads = -1;

  task automatic note(input string msg);
    viol++;
    $display("[TB] monitor violation: %s (cycle %0d)", msg, cyc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      fifo_m.delete();
      out_m = 0;
    end else begin
      if (read && write) note("read and write together");
      if (byteenable !== ((read || write) ? 2'b11 : 2'b00)) note("byteenable");
      if (write && (!wr_valid || writedata !== wr_data)) note("write pass-through");
      if (read && (out_m + fifo_m.size() >= DEPTH)) note("read issued with FIFO possibly overflowing");
      if (rd_valid !== (fifo_m.size() != 0)) note("rd_valid vs buffered words");
      if (rd_valid && rd_ready && fifo_m.size() > 0 && rd_data !== fifo_m[0]) note("rd_data order");
      if (done && !busy) note("done without busy");
      if (write) begin wa_q.push_back(address); wd_q.push_back(writedata); wc_q.push_back(cyc); end
      if (read) ra_q.push_back(address);
      if (done) done_q.push_back(cyc);
      if (rd_valid && rd_ready) begin
        pop_q.push_back(rd_data);
        popc_q.push_back(cyc);
        if (fifo_m.size() > 0) void'(fifo_m.pop_front());
      end
      if (readdatavalid && out_m > 0) begin
        fifo_m.push_back(readdata);
        out_m--;
      end
      if (read) out_m++;
    end
  end

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete();
    pop_q.delete(); popc_q.delete(); done_q.delete();
  endtask

  // Drive one command to completion. wv_mode: 0 hold, 1 toggle, 2 random.
  // rr_mode: 0 always ready, 1 not ready for 20 cycles then ready, 2 random.
  task automatic run_cmd(input bit w, input logic [19:0] a, input int len,
                         input int wv_mode, input int rr_mode);
    int  n, t, k;
    bit  fin, wv;
    clear_logs();
    exp_wd.delete();
    for (int i = 0; i < len; i++) exp_wd.push_back(16'($urandom));
    hold_reads = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = 20'(len);
    wr_valid = 1'b0; rd_ready = (rr_mode == 0);
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1", cmd_ready);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0; k = 0; fin = 0;
    while (!fin && n < 400) begin
      case (wv_mode)
        0:       wv = 1'b1;
        1:       wv = (n % 2 == 0);
        default: wv = 1'($urandom_range(0, 1));
      endcase
      wr_valid = w && (k < len) && wv;
      wr_data  = (k < len) ? exp_wd[k] : 16'($urandom);
      case (rr_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (n >= 20);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (wr_valid && wr_ready) k++;
      if (done) fin = 1;
      #1;
      if (n == 19) hold_reads = ra_q.size();
      @(posedge clk); #1;
      n++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL done_timeout: no done within 400 cycles, required a done pulse");
    end
  endtask

  // Compare the logs of the last run against the command's expected effect.
  task automatic verify_transfer(input string tag, input bit w, input logic [19:0] a, input int len);
    logic [19:0] ea;
    @(negedge clk); #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_after_done: cmd_ready=%b busy=%b, required 1 0", tag, cmd_ready, busy);
    end
    n_tests++;
    if (done_q.size() !== 1) begin
      n_fail++;
      $display("FAIL %s_done_count: %0d pulses, required 1", tag, done_q.size());
    end
    n_tests++;
    if (wa_q.size() !== (w ? len : 0) || ra_q.size() !== (w ? 0 : len)) begin
      n_fail++;
      $display("FAIL %s_access_count: writes=%0d reads=%0d, required %0d %0d",
               tag, wa_q.size(), ra_q.size(), w ? len : 0, w ? 0 : len);
    end else begin
      for (int i = 0; i < len; i++) begin
        ea = a + 20'(i);
        n_tests++;
        if (w && (wa_q[i] !== ea || wd_q[i] !== exp_wd[i])) begin
          n_fail++;
          $display("FAIL %s_write[%0d]: addr=%h data=%h, required %h %h",
                   tag, i, wa_q[i], wd_q[i], ea, exp_wd[i]);
        end else if (!w && ra_q[i] !== ea) begin
          n_fail++;
          $display("FAIL %s_read_addr[%0d]: %h, required %h", tag, i, ra_q[i], ea);
        end
      end
    end
    if (!w) begin
      n_tests++;
      if (pop_q.size() !== len) begin
        n_fail++;
        $display("FAIL %s_pop_count: %0d, required %0d", tag, pop_q.size(), len);
      end else begin
        for (int i = 0; i < len; i++) begin
          n_tests++;
          if (pop_q[i] !== mem_word(a + 20'(i))) begin
            n_fail++;
            $display("FAIL %s_rd_data[%0d]: %h, required %h", tag, i, pop_q[i], mem_word(a + 20'(i)));
          end
        end
      end
    end
    n_tests++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL %s_protocol: %0d monitor violations, required 0", tag, viol);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({read, write, address, writedata, byteenable, rd_valid, wr_ready, busy, done, cmd_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h wd=%h be=%b rv=%b wrdy=%b busy=%b done=%b crdy=%b, required all 0",
               read, write, address, writedata, byteenable, rd_valid, wr_ready, busy, done, cmd_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_basic();
    run_cmd(1'b1, 20'h00010, 3, 0, 0);
    exp_wd[0] = 16'hAAAA; exp_wd[1] = 16'hBBBB; exp_wd[2] = 16'hCCCC;
    // rerun with the fixed words so the exact data pattern is exercised
    begin
      int n, t;
      clear_logs();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00010; cmd_len = 20'd3;
      t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      acc_cyc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wr_valid = 1'b1;
      for (n = 0; n < 3; n++) begin
        wr_data = exp_wd[n];
        @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      @(posedge clk); #1;
    end
    n_tests++;
    if (wc_q.size() !== 3 || wc_q[0] !== acc_cyc + 1 || wc_q[2] !== acc_cyc + 3) begin
      n_fail++;
      $display("FAIL write_timing: %0d writes first/last cycle offsets %0d/%0d, required 3 at 1/3",
               wc_q.size(), wc_q.size() > 0 ? wc_q[0] - acc_cyc : -1, wc_q.size() > 2 ? wc_q[2] - acc_cyc : -1);
    end
    n_tests++;
    if (done_q.size() !== 1 || done_q[0] !== acc_cyc + 4) begin
      n_fail++;
      $display("FAIL write_done_timing: done offset %0d, required 4", done_q.size() > 0 ? done_q[0] - acc_cyc : -1);
    end
    verify_transfer("write_basic", 1'b1, 20'h00010, 3);
  endtask

  task automatic test_read_wrap();
    mem_lat = 2;
    run_cmd(1'b0, 20'hFFFFE, 4, 0, 0);
    n_tests++;
    if (done_q.size() !== 1 || popc_q.size() !== 4 || done_q[0] <= popc_q[3]) begin
      n_fail++;
      $display("FAIL read_wrap_done_after_pop: done=%0d pops=%0d, required done after last pop",
               done_q.size() > 0 ? done_q[0] : -1, popc_q.size());
    end
    verify_transfer("read_wrap", 1'b0, 20'hFFFFE, 4);
  endtask

  task automatic test_backpressure();
    logic [19:0] a;
    a = 20'($urandom);
    mem_lat = 2;
    run_cmd(1'b0, a, 8, 0, 1);
    n_tests++;
    if (hold_reads !== DEPTH) begin
      n_fail++;
      $display("FAIL backpressure_reads_held: %0d reads before rd_ready, required %0d", hold_reads, DEPTH);
    end
    verify_transfer("backpressure", 1'b0, a, 8);
  endtask

  task automatic test_zero_len();
    run_cmd(1'b0, 20'h12345, 0, 0, 0);
    n_tests++;
    if (done_q.size() !== 1 || done_q[0] !== acc_cyc + 1) begin
      n_fail++;
      $display("FAIL zero_len_done_timing: offset %0d, required 1", done_q.size() > 0 ? done_q[0] - acc_cyc : -1);
    end
    verify_transfer("zero_len", 1'b0, 20'h12345, 0);
    // stray return while idle must not reach the read stream
    @(posedge clk); #1;
    spur = 1'b1; rd_ready = 1'b0;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_return: rd_valid=%b, required 0", rd_valid);
    end
  endtask

  task automatic test_write_toggle();
    logic [19:0] a;
    a = 20'hFFFFE;
    run_cmd(1'b1, a, 4, 1, 0);
    n_tests++;
    if (wc_q.size() !== 4 || wc_q[3] - wc_q[0] !== 6) begin
      n_fail++;
      $display("FAIL write_toggle_spacing: %0d writes span %0d, required 4 span 6",
               wc_q.size(), wc_q.size() > 3 ? wc_q[3] - wc_q[0] : -1);
    end
    verify_transfer("write_toggle", 1'b1, a, 4);
  endtask

  task automatic test_reset_midread();
    logic [19:0] a;
    int          t, seen;
    a = 20'($urandom);
    mem_lat = 2;
    clear_logs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = 20'd8; rd_ready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (ra_q.size() !== 2) begin
      n_fail++;
      $display("FAIL midreset_outstanding: %0d reads before reset, required 2", ra_q.size());
    end
    n_tests++;
    if ({read, write, address, writedata, byteenable, rd_valid, wr_ready, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rd=%b wr=%b addr=%h be=%b rv=%b busy=%b, required all 0",
               read, write, address, byteenable, rd_valid, busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    rd_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_valid || read || write || busy) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midreset_late_data: %0d active cycles after release, required 0", seen);
    end
    rd_ready = 1'b0;
    run_cmd(1'b0, a + 20'd100, 5, 0, 0);
    verify_transfer("after_reset", 1'b0, a + 20'd100, 5);
  endtask

  task automatic test_random();
    bit          w;
    logic [19:0] a;
    int          len;
    for (int it = 0; it < 12; it++) begin
      w       = 1'($urandom_range(0, 1));
      a       = ($urandom_range(0, 2) == 0) ? 20'hFFFF0 + 20'($urandom_range(0, 15)) : 20'($urandom);
      len     = $urandom_range(1, 12);
      mem_lat = $urandom_range(1, 4);
      run_cmd(w, a, len, $urandom_range(0, 2), w ? 0 : 2 * $urandom_range(0, 1));
      verify_transfer($sformatf("random%0d", it), w, a, len);
    end
  endtask

  initial begin
    mem_seed = 16'($urandom);
    test_reset();
    test_write_basic();
    test_read_wrap();
    test_backpressure();
    test_zero_len();
    test_write_toggle();
    test_reset_midread();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_dma_master.md
SRAM_DMA_MASTER -- requirements
Module: sram_dma_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the read-return buffer depth and the cap on outstanding reads (power of 2, 2..16).
REQ-002 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_addr in 20 (start word address), cmd_len in 20 (word count).
REQ-005 SHALL have ports wr_data in 16, wr_valid in 1, wr_ready out 1, forming the write-data stream.
REQ-006 SHALL have ports rd_data out 16, rd_valid out 1, rd_ready in 1, forming the read-data stream.
REQ-007 SHALL have memory-side ports address out 20, byteenable out 2, read out 1, write out 1, writedata out 16, readdata in 16, readdatavalid in 1; the memory side has no waitrequest.
REQ-008 SHALL have ports busy out 1 and done out 1 (single-cycle pulse).

Function
REQ-009 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted on a cycle with cmd_valid and cmd_ready both high, latching addr, len and direction.
REQ-011 On acceptance, SHALL go from IDLE to WRITE or READ per cmd_write; if cmd_len is 0, SHALL go directly to DONE.
REQ-012 SHALL treat every memory read or write as accepted in the cycle it is asserted; read and write are never high together.
REQ-013 SHALL drive byteenable 2'b11 whenever read or write is high, and 2'b00 otherwise.
REQ-014 SHALL assert wr_ready in WRITE only; each wr_valid && wr_ready cycle drives write=1 with address=current address and writedata=wr_data in that same cycle (combinational pass-through).
REQ-015 SHALL increment the current address by 1 modulo 2^20 after each issued access; 20'hFFFFF wraps to 20'h00000.
REQ-016 SHALL decrement a remaining-word counter on each issued access; on the access that takes it from 1 to 0, SHALL move WRITE->DONE or READ->DRAIN.
REQ-017 In READ, SHALL issue read=1 on a cycle only if outstanding reads plus FIFO occupancy is less than FIFO_DEPTH, so that returns never overflow the FIFO.
REQ-018 SHALL push readdata into the FIFO on every readdatavalid while outstanding>0 and decrement outstanding; readdatavalid with outstanding=0 SHALL be ignored.
REQ-019 Same-cycle read issue and readdatavalid SHALL leave outstanding unchanged.
REQ-020 SHALL present the FIFO head on rd_data with rd_valid=!empty; pop on rd_valid && rd_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-021 SHALL move DRAIN->DONE when outstanding=0 and the FIFO is empty.
REQ-022 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Read return order SHALL equal issue order, and the first word delivered SHALL correspond to cmd_addr.

Reset
REQ-025 While reset=0, SHALL force state=IDLE, read=write=0, address=0, writedata=0, byteenable=0, outstanding=0, FIFO empty, rd_valid=0, wr_ready=0, busy=0, done=0; cmd_ready is 1 one cycle after release.
REQ-026 Reset asserted mid-transfer SHALL abort immediately with no further accesses; read data arriving later SHALL be discarded (outstanding=0).

Verification
REQ-027 Write cmd addr=0x00010 len=3, wr_data 0xAAAA,0xBBBB,0xCCCC with wr_valid held high -> write at 0x10,0x11,0x12 on 3 consecutive cycles, byteenable=11, done pulse one cycle later.
REQ-028 Read cmd addr=0xFFFFE len=4, memory model with 2-cycle latency, rd_ready=1 -> reads at 0xFFFFE,0xFFFFF,0x00000,0x00001; rd_data in that order; done after the last pop.
REQ-029 Read len=8, FIFO_DEPTH=4, rd_ready=0 -> exactly 4 reads issued then read stays 0; raising rd_ready -> remaining 4 issued; all 8 words delivered, none lost.
REQ-030 cmd_len=0 -> no read or write; done pulses on the cycle after acceptance; cmd_ready returns the cycle after that.
REQ-031 Write len=4 with wr_valid toggling 1,0,1,0... -> exactly 4 writes with contiguous addresses, no write on wr_valid=0 cycles.
REQ-032 Reset asserted with 2 reads outstanding, then released -> all outputs at reset values; late readdatavalid produces no rd_valid.
